// File: rtl/block_ram_arbiter_pkg.sv
// rtl/block_ram_arbiter_pkg.sv - shared side encoding for the block RAM arbiter
package block_ram_arbiter_pkg;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_t;

  function automatic side_t other_side(side_t s);
    return (s == SIDE_A) ? SIDE_B : SIDE_A;
  endfunction

endpackage

// File: rtl/block_ram_arbiter_if.sv
// rtl/block_ram_arbiter_if.sv - one requester's read/write handshake bundle
interface block_ram_arbiter_if #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10
);

  logic                     write_request;
  logic [ADDRESS_WIDTH-1:0] write_address;
  logic [WORD_WIDTH-1:0]    write_data;
  logic                     write_grant;
  logic                     read_request;
  logic [ADDRESS_WIDTH-1:0] read_address;
  logic                     read_grant;
  logic                     read_valid;

  modport master (
    output write_request, write_address, write_data, read_request, read_address,
    input  write_grant, read_grant, read_valid
  );

  modport slave (
    input  write_request, write_address, write_data, read_request, read_address,
    output write_grant, read_grant, read_valid
  );

endinterface

// File: rtl/block_ram_arbiter_rr_burst_arbiter.sv
// rtl/block_ram_arbiter_rr_burst_arbiter.sv - two-way round-robin arbiter with a burst cap
module rr_burst_arbiter
  import block_ram_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic request_a,
  input  logic request_b,
  output logic grant_a,
  output logic grant_b
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CAP = CW'(MAX_BURST);

  side_t         prio, prio_next;
  side_t         last, last_next;
  logic [CW-1:0] count, count_next;
  side_t         winner;
  logic          any;

  always_comb begin
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    winner     = SIDE_A;
    any        = 1'b0;
    prio_next  = prio;
    last_next  = last;
    count_next = count;
    if (!reset) begin
      any = request_a | request_b;
      if (request_a && request_b) begin
        winner = prio;
        // a prio side that has exhausted its run yields to the waiting side
        if (prio == last && count == CAP) winner = other_side(prio);
      end else if (request_b) begin
        winner = SIDE_B;
      end
      grant_a = any && (winner == SIDE_A);
      grant_b = any && (winner == SIDE_B);
    end
    if (any) begin
      count_next = (last == winner) ? ((count == CAP) ? CAP : count + 1'b1) : CW'(1);
      last_next  = winner;
      prio_next  = other_side(winner);
    end else begin
      count_next = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prio  <= SIDE_A;
      last  <= SIDE_A;
      count <= '0;
    end else begin
      prio  <= prio_next;
      last  <= last_next;
      count <= count_next;
    end
  end

endmodule

// File: rtl/block_ram_arbiter.sv
// rtl/block_ram_arbiter.sv - shares one simple dual-port block RAM between requesters A and B
module block_ram_arbiter
  import block_ram_arbiter_pkg::*;
#(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10,
  parameter int MAX_BURST     = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  block_ram_arbiter_if.slave       a,
  block_ram_arbiter_if.slave       b,
  output logic [WORD_WIDTH-1:0]    read_data,
  output logic                     ram_write,
  output logic [ADDRESS_WIDTH-1:0] ram_write_address,
  output logic [WORD_WIDTH-1:0]    ram_write_data,
  output logic [ADDRESS_WIDTH-1:0] ram_read_address,
  input  logic [WORD_WIDTH-1:0]    ram_read_data
);

  logic  write_grant_a, write_grant_b;
  logic  read_grant_a, read_grant_b;
  logic  read_valid_a, read_valid_b;
  side_t write_side, read_side;

  rr_burst_arbiter #(.MAX_BURST(MAX_BURST)) write_arb (
    .clock     (clock),
    .reset     (reset),
    .request_a (a.write_request),
    .request_b (b.write_request),
    .grant_a   (write_grant_a),
    .grant_b   (write_grant_b)
  );

  rr_burst_arbiter #(.MAX_BURST(MAX_BURST)) read_arb (
    .clock     (clock),
    .reset     (reset),
    .request_a (a.read_request),
    .request_b (b.read_request),
    .grant_a   (read_grant_a),
    .grant_b   (read_grant_b)
  );

  assign a.write_grant = write_grant_a;
  assign b.write_grant = write_grant_b;
  assign a.read_grant  = read_grant_a;
  assign b.read_grant  = read_grant_b;
  assign a.read_valid  = read_valid_a;
  assign b.read_valid  = read_valid_b;
  assign read_data     = ram_read_data;

  // idle ports leave the RAM pointed at side A
  always_comb begin
    write_side        = write_grant_b ? SIDE_B : SIDE_A;
    read_side         = read_grant_b ? SIDE_B : SIDE_A;
    ram_write         = write_grant_a | write_grant_b;
    ram_write_address = (write_side == SIDE_B) ? b.write_address : a.write_address;
    ram_write_data    = (write_side == SIDE_B) ? b.write_data : a.write_data;
    ram_read_address  = (read_side == SIDE_B) ? b.read_address : a.read_address;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      read_valid_a <= 1'b0;
      read_valid_b <= 1'b0;
    end else begin
      read_valid_a <= read_grant_a;
      read_valid_b <= read_grant_b;
    end
  end

endmodule

// File: tb/tb_block_ram_arbiter.sv
// tb/tb_block_ram_arbiter.sv - self-checking bench for block_ram_arbiter with a behavioural RAM
module tb_block_ram_arbiter;

  localparam int WW = 32;
  localparam int AW = 10;
  localparam int MB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [WW-1:0] read_data;
  logic          ram_write;
  logic [AW-1:0] ram_write_address;
  logic [WW-1:0] ram_write_data;
  logic [AW-1:0] ram_read_address;
  logic [WW-1:0] ram_read_data;

  block_ram_arbiter_if #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) a_if ();
  block_ram_arbiter_if #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) b_if ();

  block_ram_arbiter #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clock             (clock),
    .reset             (reset),
    .a                 (a_if),
    .b                 (b_if),
    .read_data         (read_data),
    .ram_write         (ram_write),
    .ram_write_address (ram_write_address),
    .ram_write_data    (ram_write_data),
    .ram_read_address  (ram_read_address),
    .ram_read_data     (ram_read_data)
  );

  // simple dual-port RAM, registered read, old data on collision
  bit [WW-1:0] ram [1024];
  always @(posedge clock) begin
    if (ram_write) ram[ram_write_address] <= ram_write_data;
    ram_read_data <= ram[ram_read_address];
  end

  always #5 clock = ~clock;

  typedef struct {
    bit            rst, a_rd, b_rd, a_wr, b_wr;
    logic [AW-1:0] a_addr, b_addr;
    logic [WW-1:0] a_data, b_data;
    bit            e_a_rd, e_b_rd, e_a_wr, e_b_wr;
  } vec_t;

  vec_t tbl[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model: 0 = no grant, 1 = A, 2 = B
  int          last_rd = 0, last_wr = 0;
  bit          exp_va = 0, exp_vb = 0;
  logic [WW-1:0] exp_rdata = '0;
  bit [WW-1:0] mem_m [1024];

  function automatic vec_t mk(bit rst, bit ard, bit brd, bit awr, bit bwr, int aa, int ba,
                              logic [WW-1:0] ad, logic [WW-1:0] bd,
                              bit ea, bit eb, bit ewa, bit ewb);
    vec_t v;
    v.rst = rst; v.a_rd = ard; v.b_rd = brd; v.a_wr = awr; v.b_wr = bwr;
    v.a_addr = AW'(aa); v.b_addr = AW'(ba); v.a_data = ad; v.b_data = bd;
    v.e_a_rd = ea; v.e_b_rd = eb; v.e_a_wr = ewa; v.e_b_wr = ewb;
    return v;
  endfunction

  // contended requests go to whoever was not served last; first contention goes to A
  function automatic int pick(bit rst, bit ra, bit rb, int last);
    if (rst || !(ra || rb)) return 0;
    if (ra && !rb) return 1;
    if (rb && !ra) return 2;
    return (last == 1) ? 2 : 1;
  endfunction

  task automatic chk1(string name, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(vec_t v);
    reset = v.rst;
    a_if.read_request  = v.a_rd;  a_if.read_address  = v.a_addr;
    a_if.write_request = v.a_wr;  a_if.write_address = v.a_addr;  a_if.write_data = v.a_data;
    b_if.read_request  = v.b_rd;  b_if.read_address  = v.b_addr;
    b_if.write_request = v.b_wr;  b_if.write_address = v.b_addr;  b_if.write_data = v.b_data;
    #1;
  endtask

  task automatic tick();
    int rw, ww;
    @(negedge clock);
    rw = pick(reset, a_if.read_request, b_if.read_request, last_rd);
    ww = pick(reset, a_if.write_request, b_if.write_request, last_wr);
    chk1("m_a_read_grant", a_if.read_grant, rw == 1);
    chk1("m_b_read_grant", b_if.read_grant, rw == 2);
    chk1("m_a_write_grant", a_if.write_grant, ww == 1);
    chk1("m_b_write_grant", b_if.write_grant, ww == 2);
    chk1("m_ram_write", ram_write, ww != 0);
    if (ww != 0) begin
      chkw("m_ram_write_address", 32'(ram_write_address),
           32'((ww == 1) ? a_if.write_address : b_if.write_address));
      chkw("m_ram_write_data", ram_write_data, (ww == 1) ? a_if.write_data : b_if.write_data);
    end
    if (rw != 0)
      chkw("m_ram_read_address", 32'(ram_read_address),
           32'((rw == 1) ? a_if.read_address : b_if.read_address));
    chk1("m_a_read_valid", a_if.read_valid, exp_va);
    chk1("m_b_read_valid", b_if.read_valid, exp_vb);
    if (exp_va || exp_vb) chkw("m_read_data", read_data, exp_rdata);
    @(posedge clock);
    if (reset) begin
      exp_va = 0; exp_vb = 0; last_rd = 0; last_wr = 0;
    end else begin
      exp_va = (rw == 1);
      exp_vb = (rw == 2);
      if (rw != 0) exp_rdata = mem_m[(rw == 1) ? a_if.read_address : b_if.read_address];
      if (ww == 1) mem_m[a_if.write_address] = a_if.write_data;
      if (ww == 2) mem_m[b_if.write_address] = b_if.write_data;
      if (rw != 0) last_rd = rw;
      if (ww != 0) last_wr = ww;
    end
    #1;
  endtask

  initial begin
    vec_t v;
    drive(mk(1, 0, 0, 0, 0, 0, 0, '0, '0, 0, 0, 0, 0));
    repeat (2) @(posedge clock);
    #1;

    tbl.push_back(mk(1, 1, 1, 1, 1, 3, 4, 32'h1, 32'h2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 3, 4, 32'h1, 32'h2, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 1, 1, 0, 0, k, k + 8, '0, '0, (k % 2) == 0, (k % 2) == 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, '0, '0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 1, 0, 0, 0, 5, 0, '0, '0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 5, 6, '0, '0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 5, 6, '0, '0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 5, 6, '0, '0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 7, 9, 32'h22, 32'h99, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 7, 9, 32'h22, 32'h99, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 5, 7, 32'hDEADBEEF, '0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, '0, '0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      chk1("t_a_read_grant", a_if.read_grant, tbl[i].e_a_rd);
      chk1("t_b_read_grant", b_if.read_grant, tbl[i].e_b_rd);
      chk1("t_a_write_grant", a_if.write_grant, tbl[i].e_a_wr);
      chk1("t_b_write_grant", b_if.write_grant, tbl[i].e_b_wr);
      if (tbl[i].rst) chk1("t_ram_write_reset", ram_write, 1'b0);
      tick();
    end

    // A alone reads addr 5
    drive(mk(0, 1, 0, 0, 0, 5, 0, '0, '0, 0, 0, 0, 0));
    chk1("h_a_read_grant_same_cycle", a_if.read_grant, 1'b1);
    tick();
    chk1("h_a_read_valid", a_if.read_valid, 1'b1);
    chkw("h_read_data_deadbeef", read_data, 32'hDEADBEEF);
    chk1("h_b_read_valid_idle", b_if.read_valid, 1'b0);

    // same-cycle write and read of addr 7 returns old data
    drive(mk(0, 0, 1, 1, 0, 7, 7, 32'h11, '0, 0, 0, 0, 0));
    chk1("h_collide_a_write_grant", a_if.write_grant, 1'b1);
    chk1("h_collide_b_read_grant", b_if.read_grant, 1'b1);
    tick();
    chk1("h_collide_b_valid", b_if.read_valid, 1'b1);
    chkw("h_collide_old_data", read_data, 32'h22);
    drive(mk(0, 0, 1, 0, 0, 0, 7, '0, '0, 0, 0, 0, 0));
    tick();
    chkw("h_after_write_new_data", read_data, 32'h11);

    // read request during reset: no grant, no valid, prio back to A
    drive(mk(0, 1, 0, 0, 0, 3, 0, '0, '0, 0, 0, 0, 0));
    tick();
    drive(mk(1, 0, 1, 0, 0, 0, 7, '0, '0, 0, 0, 0, 0));
    chk1("h_reset_b_read_grant", b_if.read_grant, 1'b0);
    tick();
    chk1("h_reset_b_valid", b_if.read_valid, 1'b0);
    drive(mk(0, 1, 1, 0, 0, 1, 2, '0, '0, 0, 0, 0, 0));
    chk1("h_post_reset_a_grant", a_if.read_grant, 1'b1);
    chk1("h_post_reset_b_grant", b_if.read_grant, 1'b0);
    tick();
    chk1("h_post_reset_a_valid", a_if.read_valid, 1'b1);
    chk1("h_post_reset_b_valid", b_if.read_valid, 1'b0);

    for (int n = 0; n < 400; n++) begin
      v = mk($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 15), $urandom_range(0, 15), $urandom, $urandom, 0, 0, 0, 0);
      drive(v);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
